// File: rtl/vgascanout.sv
// Pixel scanout stage: FWFT pixel FIFO feeding a registered RGB/sync output, locked to frame
// starts via tuser, blanking and resynchronising on starvation or misalignment.
module vgascanout #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        hblank,
  input  logic        vblank,
  input  logic        select,
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic [23:0] s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tuser,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        underflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StHunt, StFill, StRun, StFlush} state_e;

  state_e          state_q, state_d;
  logic [24:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [23:0]     rgb_q, rgb_d;
  logic            hsync_q, vsync_q, uf_q, uf_d;

  logic        accept, push, pop, active, origin, empty;
  logic [24:0] head;

  // Gated by reset so the handshake is quiet while the block is held in reset.
  assign s_tready = aresetn && (state_q != StFlush) && (count_q < CW'(FIFO_DEPTH));
  assign accept   = s_tvalid && s_tready;
  assign active   = select && !hblank && !vblank;
  assign origin   = (x == 12'd0) && (y == 12'd0);
  assign empty    = (count_q == '0);
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    pop     = 1'b0;
    uf_d    = uf_q;
    rgb_d   = '0;
    unique case (state_q)
      StHunt: begin
        if (accept && s_tuser) begin
          push    = 1'b1;
          state_d = StFill;
        end
      end
      StFill: begin
        push = accept;
        if (active && origin) begin
          pop     = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        push = accept;
        if (active) begin
          // A frame-start tag must coincide exactly with the (0,0) slot.
          if (empty || (head[24] != origin)) begin
            uf_d    = 1'b1;
            state_d = StFlush;
          end else begin
            pop = 1'b1;
          end
        end
      end
      StFlush: state_d = StHunt;
      default: state_d = StHunt;
    endcase
    if (pop) rgb_d = head[23:0];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (state_q == StFlush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= StHunt;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rgb_q    <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rgb_q    <= rgb_d;
      hsync_q  <= hsync;
      vsync_q  <= vsync;
      uf_q     <= uf_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= {s_tuser, s_tdata};
  end

  assign vga_r     = rgb_q[23:16];
  assign vga_g     = rgb_q[15:8];
  assign vga_b     = rgb_q[7:0];
  assign vga_hsync = hsync_q;
  assign vga_vsync = vsync_q;
  assign underflow = uf_q;

endmodule

// File: tb/tb_vgascanout.sv
// Directed plus randomised bench for vgascanout against a queue-based scanout model.
module tb_vgascanout;

  localparam int unsigned DEPTH = 16;
  // Model modes: searching for a frame tag, waiting for (0,0), streaming, one-cycle drop.
  localparam int SEEK = 0, PRIME = 1, SHOW = 2, DROP = 3;

  logic        aclk = 1'b0, aresetn = 1'b0;
  logic        hsync, vsync, hblank, vblank, select;
  logic [11:0] x, y;
  logic [23:0] s_tdata;
  logic        s_tvalid, s_tuser, s_tready;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hsync, vga_vsync, underflow;

  vgascanout #(.FIFO_DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn), .hsync(hsync), .vsync(vsync), .hblank(hblank),
    .vblank(vblank), .select(select), .x(x), .y(y), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .s_tuser(s_tuser), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .underflow(underflow)
  );

  always #5 aclk = ~aclk;

  int tests = 0, fails = 0;
  logic [24:0] q[$];
  int          mode = SEEK;
  bit          uf_m = 1'b0, exp_hs = 1'b0, exp_vs = 1'b0, last_acc = 1'b0;
  logic [23:0] exp_rgb = '0;
  int          acc_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mode = SEEK; uf_m = 0; exp_hs = 0; exp_vs = 0; exp_rgb = '0;
  endtask

  task automatic idle();
    select = 0; hblank = 1'($urandom); vblank = 1'($urandom);
    x = 12'($urandom); y = 12'($urandom);
    s_tvalid = 0; s_tdata = 24'($urandom); s_tuser = 1'($urandom);
    hsync = 1'($urandom); vsync = 1'($urandom);
  endtask

  // One clock: check handshake before the edge, advance model, check outputs after it.
  task automatic step();
    bit rdy, act, org, acc, hs, vs;
    logic [24:0] h;
    logic [23:0] disp;
    int nmode;
    #1;
    rdy = (mode != DROP) && (q.size() < DEPTH);
    check("s_tready", 32'(s_tready), 32'(rdy));
    last_acc = s_tvalid && s_tready;
    act = select && !hblank && !vblank;
    org = (x == 0) && (y == 0);
    acc = s_tvalid && rdy;
    hs = hsync; vs = vsync;
    disp = '0; nmode = mode;
    case (mode)
      SEEK: if (acc && s_tuser) begin q.push_back({1'b1, s_tdata}); nmode = PRIME; end
      PRIME: begin
        if (act && org) begin h = q.pop_front(); disp = h[23:0]; nmode = SHOW; end
        if (acc) q.push_back({s_tuser, s_tdata});
      end
      SHOW: begin
        if (act) begin
          if (q.size() == 0 || (q[0][24] && !org) || (!q[0][24] && org)) begin
            uf_m = 1; nmode = DROP;
          end else begin
            h = q.pop_front(); disp = h[23:0];
          end
        end
        if (acc) q.push_back({s_tuser, s_tdata});
      end
      default: begin q.delete(); nmode = SEEK; end
    endcase
    @(posedge aclk);
    mode = nmode; exp_rgb = disp; exp_hs = hs; exp_vs = vs;
    #1;
    check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
    check("hsync", 32'(vga_hsync), 32'(exp_hs));
    check("vsync", 32'(vga_vsync), 32'(exp_vs));
    check("underflow", 32'(underflow), 32'(uf_m));
  endtask

  task automatic slot(input logic [11:0] xx, input logic [11:0] yy);
    idle(); select = 1; hblank = 0; vblank = 0; x = xx; y = yy; step();
  endtask

  task automatic blank_slot();
    idle(); select = 1; hblank = 1; x = 12'd2; y = 12'd0; step();
  endtask

  task automatic beat(input logic [23:0] d, input logic u);
    idle(); s_tvalid = 1; s_tdata = d; s_tuser = u; step();
  endtask

  task automatic check_zero(input string tag);
    check(tag, 32'({vga_r, vga_g, vga_b, vga_hsync, vga_vsync, underflow, s_tready}), 32'd0);
  endtask

  initial begin
    logic [23:0] d;
    int gi, rx, ry;
    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      idle(); s_tvalid = 1'($urandom);
      #2; check_zero("reset_outputs");
      @(posedge aclk); #1;
    end
    aresetn = 1; model_reset();
    idle(); step();

    // Lock and display.
    for (int i = 0; i < 3; i++) beat(24'($urandom), 1'b0);
    beat(24'h112233, 1'b1);
    beat(24'h445566, 1'b0);
    blank_slot();
    slot(12'd0, 12'd0);
    check("lock_px0", 32'({vga_r, vga_g, vga_b}), 32'h112233);
    blank_slot();
    slot(12'd1, 12'd0);
    check("lock_px1", 32'({vga_r, vga_g, vga_b}), 32'h445566);

    // Underflow on an empty FIFO, flush, relock.
    slot(12'd5, 12'd0);
    check("uf_flag", 32'(underflow), 32'd1);
    idle(); s_tvalid = 1; step();
    d = 24'($urandom);
    beat(d, 1'b1);
    slot(12'd0, 12'd0);
    check("relock_px", 32'({vga_r, vga_g, vga_b}), 32'(d));

    // Misaligned frame tag at (7,3); the tagged entry must not survive the flush.
    beat(24'hA0A0A0, 1'b0);
    beat(24'hC0C0C0, 1'b1);
    slot(12'd1, 12'd0);
    slot(12'd7, 12'd3);
    check("misalign_black", 32'({vga_r, vga_g, vga_b}), 32'd0);
    idle(); step();
    beat(24'hD1D2D3, 1'b1);
    slot(12'd0, 12'd0);
    check("misalign_relock", 32'({vga_r, vga_g, vga_b}), 32'hD1D2D3);

    // Mid-frame asynchronous reset.
    beat(24'hE0E0E0, 1'b0);
    slot(12'd1, 12'd0);
    aresetn = 0;
    #1; check_zero("midreset_outputs");
    @(posedge aclk); #1;
    aresetn = 1; model_reset();

    // Relock, then fill to capacity with no active slots.
    acc_cnt = 0;
    beat(24'hF1F2F3, 1'b1);
    if (last_acc) acc_cnt++;
    for (int i = 0; i < 19; i++) begin
      beat(24'($urandom), 1'b0);
      if (last_acc) acc_cnt++;
    end
    check("full_accepts", 32'(acc_cnt), 32'd16);
    slot(12'd0, 12'd0);
    check("full_first_px", 32'({vga_r, vga_g, vga_b}), 32'hF1F2F3);
    idle(); s_tvalid = 1; step();

    // Randomised raster (4x3 active inside 6x4) with a tagged 12-pixel producer.
    gi = 0; rx = 0; ry = 0;
    for (int n = 0; n < 800; n++) begin
      idle();
      s_tvalid = ($urandom_range(0, 9) < 8);
      s_tuser  = (gi == 0);
      select   = ($urandom_range(0, 9) < 7);
      hblank   = (rx >= 4);
      vblank   = (ry >= 3);
      x = 12'(rx); y = 12'(ry);
      step();
      if (last_acc) gi = (gi + 1) % 12;
      if (select) begin
        rx++;
        if (rx == 6) begin rx = 0; ry = (ry + 1) % 4; end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
